// File: rtl/mem_stage_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_dmem_ctrl
//   MEM-stage data-memory controller. Sits behind the EXE/MEM pipeline
//   register, picks the DMEM address and store-data sources, builds byte
//   strobes, runs the req/gnt/rvalid handshake and stalls the front of the
//   pipeline until the access finishes. Load data is aligned and sign- or
//   zero-extended for the MEM/WB register.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   mem_w, DatatoReg, size   access type (store / load when 2'b01 / funct3)
//   ALU_out, DMEM_Custom_Address{,_ntt,_pwam}, dmem_addr_sel
//                            address sources and select
//   Data_out, Buffer_data_out, ntt_dout, pwam_dout, dmem_data_sel
//                            store-data sources and select
//   dmem_req/we/addr/wdata/wstrb   request channel to DMEM
//   dmem_gnt, dmem_rvalid, dmem_rdata  response channel from DMEM
//   stall                    holds PC/IF/ID/EX and the EXE/MEM register
//   load_data, load_valid    extended load result and its update pulse
//   misalign, bus_err        dropped-access and timeout pulses
// ---------------------------------------------------------------------------
module mem_stage_dmem_ctrl #(
  parameter int DATA_BITS = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_w,
  input  logic [1:0]             DatatoReg,
  input  logic [2:0]             size,
  input  logic [63:0]            ALU_out,
  input  logic [63:0]            DMEM_Custom_Address,
  input  logic [63:0]            DMEM_Custom_Address_ntt,
  input  logic [63:0]            DMEM_Custom_Address_pwam,
  input  logic [1:0]             dmem_addr_sel,
  input  logic [DATA_BITS-1:0]   Data_out,
  input  logic [DATA_BITS-1:0]   Buffer_data_out,
  input  logic [DATA_BITS-1:0]   ntt_dout,
  input  logic [DATA_BITS-1:0]   pwam_dout,
  input  logic [1:0]             dmem_data_sel,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [63:0]            dmem_addr,
  output logic [DATA_BITS-1:0]   dmem_wdata,
  output logic [DATA_BITS/8-1:0] dmem_wstrb,
  input  logic                   dmem_gnt,
  input  logic                   dmem_rvalid,
  input  logic [DATA_BITS-1:0]   dmem_rdata,
  output logic                   stall,
  output logic [DATA_BITS-1:0]   load_data,
  output logic                   load_valid,
  output logic                   misalign,
  output logic                   bus_err
);

  localparam int NBYTES = DATA_BITS / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] off);
    logic ok;
    case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = (off[0] == 1'b0);
      2'b10:   ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [NBYTES-1:0] strb_mask(input logic [1:0] sz);
    logic [NBYTES-1:0] m;
    case (sz)
      2'b00:   m = NBYTES'(8'h01);
      2'b01:   m = NBYTES'(8'h03);
      2'b10:   m = NBYTES'(8'h0F);
      default: m = NBYTES'(8'hFF);
    endcase
    return m;
  endfunction

  // Size 011 and 111 both pass the full doubleword through.
  function automatic logic [DATA_BITS-1:0] load_ext(input logic [DATA_BITS-1:0] raw,
                                                    input logic [2:0] sz);
    logic [DATA_BITS-1:0] r;
    case (sz)
      3'b000:  r = {{(DATA_BITS-8){raw[7]}},   raw[7:0]};
      3'b001:  r = {{(DATA_BITS-16){raw[15]}}, raw[15:0]};
      3'b010:  r = {{(DATA_BITS-32){raw[31]}}, raw[31:0]};
      3'b100:  r = {{(DATA_BITS-8){1'b0}},     raw[7:0]};
      3'b101:  r = {{(DATA_BITS-16){1'b0}},    raw[15:0]};
      3'b110:  r = {{(DATA_BITS-32){1'b0}},    raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Source selection and access decode
  // ---------------------------------------------------------------------
  logic [63:0]          sel_addr;
  logic [DATA_BITS-1:0] sel_data;
  logic [2:0]           off;
  logic                 is_load, access, aligned, start;

  always_comb begin
    sel_addr = ALU_out;
    case (dmem_addr_sel)
      2'b01:   sel_addr = DMEM_Custom_Address;
      2'b10:   sel_addr = DMEM_Custom_Address_ntt;
      2'b11:   sel_addr = DMEM_Custom_Address_pwam;
      default: sel_addr = ALU_out;
    endcase
  end

  always_comb begin
    sel_data = Data_out;
    case (dmem_data_sel)
      2'b01:   sel_data = Buffer_data_out;
      2'b10:   sel_data = ntt_dout;
      2'b11:   sel_data = pwam_dout;
      default: sel_data = Data_out;
    endcase
  end

  assign off     = sel_addr[2:0];
  assign is_load = (DatatoReg == 2'b01);
  assign access  = mem_w | is_load;
  assign aligned = is_aligned(size[1:0], off);
  // Only IDLE may launch, so the instruction still sitting on the inputs
  // during DONE cannot start a second access.
  assign start   = (state == IDLE) && access && aligned;

  // ---------------------------------------------------------------------
  // Captured request, timeout counter and load result
  // ---------------------------------------------------------------------
  logic [63:0]          cap_addr;
  logic [DATA_BITS-1:0] cap_wdata;
  logic [NBYTES-1:0]    cap_wstrb;
  logic                 cap_we;
  logic [2:0]           cap_size;
  logic [2:0]           cap_off;
  logic [7:0]           tmo_cnt;
  logic [DATA_BITS-1:0] load_data_q;
  logic                 load_valid_q;
  logic                 busy, busy_nxt, tmo_hit, ld_accept;

  assign busy      = (state == REQ) || (state == WAIT);
  assign busy_nxt  = (state_nxt == REQ) || (state_nxt == WAIT);
  assign tmo_hit   = busy && (tmo_cnt == 8'(TIMEOUT));
  // Timeout wins over a response arriving in the same cycle.
  assign ld_accept = (state == WAIT) && dmem_rvalid && !tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_wstrb    <= '0;
      cap_we       <= 1'b0;
      cap_size     <= '0;
      cap_off      <= '0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= (busy && busy_nxt) ? tmo_cnt + 8'd1 : 8'd0;
      load_valid_q <= ld_accept;
      if (ld_accept)
        load_data_q <= load_ext(dmem_rdata >> {cap_off, 3'b000}, cap_size);
      if (start) begin
        cap_addr  <= {sel_addr[63:3], 3'b000};
        cap_wdata <= sel_data << {off, 3'b000};
        cap_wstrb <= mem_w ? (strb_mask(size[1:0]) << off) : '0;
        cap_we    <= mem_w;
        cap_size  <= size;
        cap_off   <= off;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (tmo_hit)       state_nxt = DONE;
        else if (dmem_gnt) state_nxt = cap_we ? DONE : WAIT;
      end
      WAIT: if (tmo_hit || dmem_rvalid) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs; the combinational IDLE terms are masked while reset is held
  // so every output reads 0 during reset.
  // ---------------------------------------------------------------------
  assign dmem_req   = (state == REQ) && !tmo_hit;
  assign dmem_we    = (state == REQ) && cap_we;
  assign dmem_addr  = cap_addr;
  assign dmem_wdata = cap_wdata;
  assign dmem_wstrb = cap_wstrb;
  assign stall      = rst && (start || busy);
  assign misalign   = rst && (state == IDLE) && access && !aligned;
  assign bus_err    = tmo_hit;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;

endmodule
